// File: rtl/wb_timer_if.sv
// Wishbone pipelined bus bundle between the SoC slave port and wb_timer.
// The master modport drives the request side, and the slave modport drives the response side.
interface wb_timer_if #(
  parameter int WB_ADDR_WIDTH = 16,
  parameter int WB_DATA_WIDTH = 8
);
  logic                     cyc_i;
  logic                     stb_i;
  logic                     we_i;
  logic [WB_ADDR_WIDTH-1:0] adr_i;
  logic [WB_DATA_WIDTH-1:0] dat_i;
  logic                     stall_o;
  logic                     ack_o;
  logic [WB_DATA_WIDTH-1:0] dat_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  stall_o, ack_o, dat_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output stall_o, ack_o, dat_o
  );
endinterface

// File: rtl/wb_timer.sv
// Wishbone slave: 16-bit prescaled timer/counter with compare-match flag and level irq.
// Define WB_TIMER_ONESHOT_EN to implement CTRL.b3 (ONESHOT: the match tick also clears EN).
module wb_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  wb_timer_if.slave  bus,
  output logic       irq_o
);

  logic       req, wrEn, rdEn, tick, hit, oneShotBit;
  logic [2:0] adr;
  logic [7:0] rdData;
  logic       unusedAdr;

  logic        en_q, en_d, autoReload_q, autoReload_d, irqEn_q, irqEn_d;
  logic        match_q, match_d;
  logic [7:0]  prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [15:0] count_q, count_d, cmp_q, cmp_d;
  logic [7:0]  rShadow_q, rShadow_d, wShadow_q, wShadow_d;
  logic        ack_q, ack_d, irq_q, irq_d;
  logic [7:0]  dat_q, dat_d;

  assign req       = bus.cyc_i & bus.stb_i;
  assign wrEn      = req & bus.we_i;
  assign rdEn      = req & ~bus.we_i;
  assign adr       = bus.adr_i[2:0];
  assign unusedAdr = ^bus.adr_i;

  assign tick = en_q & (pcnt_q == prescale_q);
  assign hit  = tick & (count_q == cmp_q);

`ifdef WB_TIMER_ONESHOT_EN
  logic oneShot_q, oneShot_d;

  always_comb begin
    oneShot_d = oneShot_q;
    if (wrEn && adr == 3'd0) oneShot_d = bus.dat_i[3];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) oneShot_q <= 1'b0;
    else       oneShot_q <= oneShot_d;
  end

  assign oneShotBit = oneShot_q;
`else
  assign oneShotBit = 1'b0;
`endif

  always_comb begin
    rdData = 8'h00;
    case (adr)
      3'd0: rdData = {4'b0000, oneShotBit, irqEn_q, autoReload_q, en_q};
      3'd1: rdData = {7'b0000000, match_q};
      3'd2: rdData = prescale_q;
      3'd3: rdData = count_q[7:0];
      3'd4: rdData = rShadow_q;
      3'd5: rdData = cmp_q[7:0];
      3'd6: rdData = cmp_q[15:8];
      default: rdData = 8'h00;
    endcase
  end

  always_comb begin
    en_d         = en_q;
    autoReload_d = autoReload_q;
    irqEn_d      = irqEn_q;
    prescale_d   = prescale_q;
    cmp_d        = cmp_q;
    wShadow_d    = wShadow_q;
    rShadow_d    = rShadow_q;
    match_d      = match_q;
    count_d      = count_q;
    pcnt_d       = pcnt_q;

    if (wrEn) begin
      case (adr)
        3'd0: {irqEn_d, autoReload_d, en_d} = bus.dat_i[2:0];
        3'd2: prescale_d = bus.dat_i;
        3'd4: wShadow_d = bus.dat_i;
        3'd5: cmp_d[7:0] = bus.dat_i;
        3'd6: cmp_d[15:8] = bus.dat_i;
        default: ;
      endcase
    end
    if (rdEn && adr == 3'd3) rShadow_d = count_q[15:8];
    if (hit && oneShotBit) en_d = 1'b0;

    // Hardware set beats a software clear landing on the same edge.
    if (hit)                                       match_d = 1'b1;
    else if (wrEn && adr == 3'd1 && bus.dat_i[0])  match_d = 1'b0;

    // A COUNT_LO commit replaces the tick's increment entirely.
    if (wrEn && adr == 3'd3)  count_d = {wShadow_q, bus.dat_i};
    else if (hit)             count_d = autoReload_q ? 16'h0000 : count_q + 16'd1;
    else if (tick)            count_d = count_q + 16'd1;

    if ((wrEn && adr == 3'd2) || !en_q || tick) pcnt_d = 8'h00;
    else                                        pcnt_d = pcnt_q + 8'd1;
  end

  assign ack_d = req;
  assign dat_d = rdEn ? rdData : 8'h00;
  assign irq_d = match_q & irqEn_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q         <= 1'b0;
      autoReload_q <= 1'b0;
      irqEn_q      <= 1'b0;
      match_q      <= 1'b0;
      prescale_q   <= 8'h00;
      pcnt_q       <= 8'h00;
      count_q      <= 16'h0000;
      cmp_q        <= 16'hFFFF;
      rShadow_q    <= 8'h00;
      wShadow_q    <= 8'h00;
      ack_q        <= 1'b0;
      dat_q        <= 8'h00;
      irq_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      autoReload_q <= autoReload_d;
      irqEn_q      <= irqEn_d;
      match_q      <= match_d;
      prescale_q   <= prescale_d;
      pcnt_q       <= pcnt_d;
      count_q      <= count_d;
      cmp_q        <= cmp_d;
      rShadow_q    <= rShadow_d;
      wShadow_q    <= wShadow_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.stall_o = 1'b0;
  assign bus.ack_o   = ack_q;
  assign bus.dat_o   = dat_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Scoreboard bench for wb_timer: requests push expected responses and a monitor pops them on ack.
// Expectations for CTRL.b3 and one-shot behaviour follow WB_TIMER_ONESHOT_EN.
module tb_wb_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  wb_timer_if busIf ();

  wb_timer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busIf.slave),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
    string      name;
  } expT;

  expT sbQ[$];
  int  cycCnt      = 0;
  int  vectors     = 0;
  int  miscompares = 0;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every ack must land exactly on the cycle its request predicted, and no other ack may appear.
  always @(negedge clk) begin
    expT e;
    if (!rst) begin
      if (sbQ.size() > 0 && sbQ[0].due == cycCnt) begin
        e = sbQ.pop_front();
        checkOutput({e.name, " ack/dat"}, {7'b0, busIf.ack_o, busIf.dat_o}, {8'h01, e.data});
      end else if (busIf.ack_o !== 1'b0) begin
        checkOutput($sformatf("unexpected ack @%0d", cycCnt), {15'b0, busIf.ack_o}, 16'h0000);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] adr, input logic [7:0] wdat,
                               input logic [7:0] expRd);
    expT e;
    @(negedge clk);
    busIf.cyc_i = 1'b1;
    busIf.stb_i = 1'b1;
    busIf.we_i  = we;
    busIf.adr_i = {13'($urandom), adr};
    busIf.dat_i = we ? wdat : 8'h00;
    e.data = we ? 8'h00 : expRd;
    e.due  = cycCnt + 1;
    e.name = $sformatf("%s adr%0d @%0d", we ? "wr" : "rd", adr, cycCnt + 1);
    sbQ.push_back(e);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [7:0] d);
    applyStimulus(1'b1, adr, d, 8'h00);
  endtask

  task automatic rd(input logic [2:0] adr, input logic [7:0] expRd);
    applyStimulus(1'b0, adr, 8'h00, expRd);
  endtask

  task automatic idle();
    @(negedge clk);
    busIf.cyc_i = 1'b0;
    busIf.stb_i = 1'b0;
    busIf.we_i  = 1'b0;
  endtask

  initial begin
    logic [7:0] mapExp [8];
    busIf.cyc_i = 1'b0;
    busIf.stb_i = 1'b0;
    busIf.we_i  = 1'b0;
    busIf.adr_i = '0;
    busIf.dat_i = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset ack", {15'b0, busIf.ack_o}, 16'h0000);
    checkOutput("reset dat", {8'b0, busIf.dat_o}, 16'h0000);
    checkOutput("reset irq", {15'b0, irq}, 16'h0000);
    checkOutput("stall", {15'b0, busIf.stall_o}, 16'h0000);
    rst = 1'b0;

    $display("[TB] back-to-back register map reads");
    mapExp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    wr(3'd0, 8'h00);
    for (int i = 0; i < 8; i++) rd(3'(i), mapExp[i]);
    wr(3'd7, 8'h5A);
    rd(3'd7, 8'h00);
    idle();

    $display("[TB] prescale 3, compare 5, autoreload + irq");
    wr(3'd2, 8'h03);
    wr(3'd5, 8'h05);
    wr(3'd6, 8'h00);
    wr(3'd0, 8'h07);
    idle();
    repeat (24) @(posedge clk);
    #1 checkOutput("irq before match", {15'b0, irq}, 16'h0000);
    @(posedge clk);
    #1 checkOutput("irq after match", {15'b0, irq}, 16'h0001);
    rd(3'd1, 8'h01);
    rd(3'd3, 8'h00);
    wr(3'd1, 8'h01);
    idle();
    @(posedge clk);
    #1 checkOutput("irq after clear", {15'b0, irq}, 16'h0000);

    $display("[TB] atomic count access");
    wr(3'd0, 8'h00);
    wr(3'd4, 8'h12);
    wr(3'd3, 8'h34);
    rd(3'd3, 8'h34);
    rd(3'd4, 8'h12);
    wr(3'd2, 8'h00);
    wr(3'd4, 8'h12);
    wr(3'd3, 8'hFF);
    wr(3'd0, 8'h01);
    rd(3'd3, 8'hFF);
    rd(3'd4, 8'h12);
    rd(3'd3, 8'h01);
    rd(3'd4, 8'h13);

    $display("[TB] collisions");
    wr(3'd4, 8'hAB);
    wr(3'd3, 8'hCD);
    rd(3'd3, 8'hCD);
    rd(3'd4, 8'hAB);
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
    wr(3'd5, 8'h03);
    wr(3'd6, 8'h00);
    wr(3'd4, 8'h00);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h01);
    rd(3'd3, 8'h00);
    rd(3'd3, 8'h01);
    rd(3'd3, 8'h02);
    wr(3'd1, 8'h01);
    rd(3'd1, 8'h01);
    rd(3'd3, 8'h05);
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
    rd(3'd1, 8'h00);

    $display("[TB] one-shot configuration");
    wr(3'd4, 8'h00);
    wr(3'd3, 8'h00);
    wr(3'd5, 8'h02);
    wr(3'd6, 8'h00);
    wr(3'd0, 8'h0F);
`ifdef WB_TIMER_ONESHOT_EN
    rd(3'd0, 8'h0F);
    repeat (5) idle();
    rd(3'd0, 8'h0E);
    rd(3'd3, 8'h00);
`else
    rd(3'd0, 8'h07);
    repeat (5) idle();
    rd(3'd0, 8'h07);
    rd(3'd3, 8'h01);
`endif
    rd(3'd1, 8'h01);
    idle();
    @(posedge clk);
    #1 checkOutput("irq one-shot", {15'b0, irq}, 16'h0001);

    $display("[TB] asynchronous reset mid-ack");
    rd(3'd5, 8'h02);
    @(posedge clk);
    #1 checkOutput("ack before reset", {15'b0, busIf.ack_o}, 16'h0001);
    rst = 1'b1;
    #1;
    checkOutput("ack in reset", {15'b0, busIf.ack_o}, 16'h0000);
    checkOutput("dat in reset", {8'b0, busIf.dat_o}, 16'h0000);
    checkOutput("irq in reset", {15'b0, irq}, 16'h0000);
    sbQ.delete();
    busIf.cyc_i = 1'b0;
    busIf.stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) idle();
    rd(3'd5, 8'hFF);
    rd(3'd6, 8'hFF);
    rd(3'd0, 8'h00);
    rd(3'd1, 8'h00);
    idle();

    for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(negedge clk);
    if (sbQ.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d responses outstanding, required 0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
